// File: rtl/anti_theft_ctrl_nch.sv
// N-door vehicle anti-theft controller with integrated interval timer, per-door
// trigger delay, consecutive-alarm counting and latched lockout siren.
// Optional build macro PANIC_INPUT_EN adds a panic input that forces ALARM.
module anti_theft_ctrl_nch #(
  parameter int                 N_DOORS     = 4,
  parameter logic [N_DOORS-1:0] DRIVER_MASK = 4'b0001,
  parameter int                 TW          = 32,
  parameter int                 T_ARM       = 8,
  parameter int                 T_DRIVER    = 4,
  parameter int                 T_PASS      = 6,
  parameter int                 T_ALARM     = 10,
  parameter int                 BLINK_HALF  = 25000000,
  parameter int                 MAX_ALARMS  = 2,
  localparam int                FD_W        = (N_DOORS > 1) ? $clog2(N_DOORS) : 1,
  localparam int                CNT_W       = $clog2(MAX_ALARMS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ignition,
`ifdef PANIC_INPUT_EN
  input  logic               panic,
`endif
  input  logic [N_DOORS-1:0] doors,
  output logic               led,
  output logic               siren,
  output logic [2:0]         state_o,
  output logic [FD_W-1:0]    first_door,
  output logic [CNT_W-1:0]   alarm_cnt
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIG       = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_CLOSE = 3'd4,
    ARM_DELAY  = 3'd5,
    LOCKOUT    = 3'd6
  } state_t;

  localparam logic [TW-1:0]    LD_ARM    = TW'(T_ARM - 1);
  localparam logic [TW-1:0]    LD_DRIVER = TW'(T_DRIVER - 1);
  localparam logic [TW-1:0]    LD_PASS   = TW'(T_PASS - 1);
  localparam logic [TW-1:0]    LD_ALARM  = TW'(T_ALARM - 1);
  localparam logic [TW-1:0]    BLINK_TOP = TW'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_ALARMS);

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [TW-1:0]     blink_cnt, blink_cnt_nxt;
  logic              phase, phase_nxt;
  logic [FD_W-1:0]   first_door_nxt;
  logic [CNT_W-1:0]  alarm_cnt_nxt;
  logic              led_nxt, siren_nxt;
  logic [FD_W-1:0]   low_idx;
  logic              any_door;
  logic              expired;

  assign any_door = |doors;
  assign expired  = (timer == '0);
  assign state_o  = state;

  // Lowest-index open door: scanning downward lets the smallest index win.
  always_comb begin
    low_idx = '0;
    for (int i = N_DOORS - 1; i >= 0; i--) begin
      if (doors[i]) low_idx = FD_W'(i);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_nxt      = state;
    timer_nxt      = expired ? timer : timer - TW'(1);
    blink_cnt_nxt  = '0;
    phase_nxt      = 1'b0;
    first_door_nxt = first_door;
    alarm_cnt_nxt  = alarm_cnt;

    unique case (state)
      ARMED: begin
        if (ignition) begin
          state_nxt = DISARMED;
        end else if (any_door) begin
          state_nxt      = TRIG;
          first_door_nxt = low_idx;
          timer_nxt      = DRIVER_MASK[low_idx] ? LD_DRIVER : LD_PASS;
        end else if (blink_cnt == BLINK_TOP) begin
          phase_nxt = ~phase;
        end else begin
          blink_cnt_nxt = blink_cnt + TW'(1);
          phase_nxt     = phase;
        end
      end
      TRIG: begin
        if (ignition) begin
          state_nxt = DISARMED;
        end else if (!any_door) begin
          state_nxt = ARMED;
        end else if (expired) begin
          state_nxt     = ALARM;
          timer_nxt     = LD_ALARM;
          alarm_cnt_nxt = (alarm_cnt == CNT_MAX) ? alarm_cnt : alarm_cnt + CNT_W'(1);
        end
      end
      ALARM: begin
        if (ignition) begin
          state_nxt = DISARMED;
        end else if (expired) begin
          state_nxt = (alarm_cnt == CNT_MAX) ? LOCKOUT : ARMED;
        end
      end
      LOCKOUT: begin
        if (ignition) state_nxt = DISARMED;
      end
      DISARMED: begin
        if (!ignition) begin
          if (any_door) begin
            state_nxt = WAIT_CLOSE;
          end else begin
            state_nxt = ARM_DELAY;
            timer_nxt = LD_ARM;
          end
        end
      end
      WAIT_CLOSE: begin
        if (ignition) begin
          state_nxt = DISARMED;
        end else if (!any_door) begin
          state_nxt = ARM_DELAY;
          timer_nxt = LD_ARM;
        end
      end
      ARM_DELAY: begin
        if (ignition) begin
          state_nxt = DISARMED;
        end else if (any_door) begin
          state_nxt = WAIT_CLOSE;
        end else if (expired) begin
          state_nxt = ARMED;
        end
      end
      default: begin
        state_nxt = ARMED;
      end
    endcase

`ifdef PANIC_INPUT_EN
    // Panic outranks doors and expiry but never ignition; the count is left alone.
    if (panic && !ignition && state != DISARMED && state != LOCKOUT) begin
      state_nxt      = ALARM;
      timer_nxt      = LD_ALARM;
      alarm_cnt_nxt  = alarm_cnt;
      first_door_nxt = first_door;
      blink_cnt_nxt  = '0;
      phase_nxt      = 1'b0;
    end
`endif

    if (state_nxt == DISARMED) alarm_cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_comb begin
    led_nxt   = 1'b0;
    siren_nxt = 1'b0;
    unique case (state_nxt)
      ARMED:                 led_nxt = phase_nxt;
      TRIG, ARM_DELAY:       led_nxt = 1'b1;
      ALARM, LOCKOUT: begin
        led_nxt   = 1'b1;
        siren_nxt = 1'b1;
      end
      default: begin
        led_nxt   = 1'b0;
        siren_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARMED;
      timer      <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      first_door <= '0;
      alarm_cnt  <= '0;
      led        <= 1'b0;
      siren      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      timer      <= timer_nxt;
      blink_cnt  <= blink_cnt_nxt;
      phase      <= phase_nxt;
      first_door <= first_door_nxt;
      alarm_cnt  <= alarm_cnt_nxt;
      led        <= led_nxt;
      siren      <= siren_nxt;
    end
  end

endmodule
